// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared FSM states, default tap masks and the unrolled LFSR step function
package prng_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_RUN
  } prng_state_e;

  localparam logic [7:0]   TAPS_8   = 8'hB8;
  localparam logic [31:0]  TAPS_32  = 32'h8020_0003;
  localparam logic [63:0]  TAPS_64  = 64'hD800_0000_0000_0000;
  localparam logic [127:0] TAPS_128 = 128'h6000_0000_0000_0000_0000_0000_A000_0000;

  // Widest LFSR the step function handles; callers zero-extend into it.
  localparam int MAX_W = 256;

  typedef struct packed {
    logic [MAX_W-1:0] state;
    logic [MAX_W-1:0] bits;
  } step_res_t;

  // n Fibonacci steps on a w-bit state; first-produced bit ends up at bits[n-1].
  function automatic step_res_t lfsr_step_n(input logic [MAX_W-1:0] state,
                                            input logic [MAX_W-1:0] taps,
                                            input int               n,
                                            input int               w);
    step_res_t        r;
    logic [MAX_W-1:0] mask;
    logic             fb;
    mask    = {MAX_W{1'b1}} >> (MAX_W - w);
    r.state = state & mask;
    r.bits  = '0;
    for (int i = 0; i < n; i++) begin
      r.bits  = {r.bits[MAX_W-2:0], r.state[w-1]};
      fb      = ^(r.state & taps);
      r.state = ((r.state << 1) | MAX_W'(fb)) & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/prng_step_div.sv
// rtl/prng_step_div.sv - enable-gated step divider, one tick every DIV enabled clocks
module prng_step_div #(
  parameter int DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = i_en && !i_clr && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prng_lfsr_stream.sv
// rtl/prng_lfsr_stream.sv - seeded Fibonacci LFSR keystream source with warm-up and valid/ready output
module prng_lfsr_stream
  import prng_pkg::*;
#(
  parameter int               WIDTH     = 128,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_128),
  parameter int               OUT_BITS  = 8,
  parameter int               DIV       = 8,
  parameter int               WARMUP    = 16,
  parameter logic [WIDTH-1:0] SAFE_SEED = WIDTH'(1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [WIDTH-1:0]    i_seed,
  input  logic                i_seed_valid,
  output logic                o_seed_ready,
  output logic [OUT_BITS-1:0] o_ks_data,
  output logic                o_ks_valid,
  input  logic                i_ks_ready,
  output logic [WIDTH-1:0]    o_lfsr,
  output logic                o_seeded
);

  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  prng_state_e         state_q, state_d;
  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [OUT_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                pend_q, pend_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;

  logic                tick;
  logic                step_req;
  logic                do_step;
  logic [WW-1:0]       wcnt_inc;
  step_res_t           step_res;
  logic [WIDTH-1:0]    lfsr_next;
  logic [OUT_BITS-1:0] step_word;
  logic                unused_bits;

  prng_step_div #(
    .DIV(DIV)
  ) u_div (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_en && (state_q != S_IDLE)),
    .i_clr  (i_seed_valid),
    .o_tick (tick)
  );

  assign step_res    = lfsr_step_n(MAX_W'(lfsr_q), MAX_W'(TAPS), OUT_BITS, WIDTH);
  assign lfsr_next   = step_res.state[WIDTH-1:0];
  assign step_word   = step_res.bits[OUT_BITS-1:0];
  assign unused_bits = ^(step_res.state >> WIDTH) ^ ^(step_res.bits >> OUT_BITS);

  // A fresh tick can be consumed in the same clock; pending only carries a stalled one.
  assign step_req = pend_q || tick;
  assign wcnt_inc = wcnt_q + WW'(1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    wcnt_d  = wcnt_q;
    do_step = 1'b0;
    if (i_seed_valid) begin
      lfsr_d  = (i_seed == '0) ? SAFE_SEED : i_seed;
      valid_d = 1'b0;
      pend_d  = 1'b0;
      wcnt_d  = '0;
      state_d = (WARMUP == 0) ? S_RUN : S_WARMUP;
    end else begin
      if (tick) pend_d = 1'b1;
      if (valid_q && i_ks_ready) valid_d = 1'b0;
      case (state_q)
        S_WARMUP: begin
          if (i_en && step_req) begin
            do_step = 1'b1;
            wcnt_d  = wcnt_inc;
            if (wcnt_inc == WW'(WARMUP)) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (i_en && step_req && (!valid_q || i_ks_ready)) begin
            do_step = 1'b1;
            data_d  = step_word;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (do_step) begin
        lfsr_d = lfsr_next;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SAFE_SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign o_seed_ready = 1'b1;
  assign o_ks_data    = data_q;
  assign o_ks_valid   = valid_q;
  assign o_lfsr       = lfsr_q;
  assign o_seeded     = (state_q == S_RUN);

endmodule

// File: tb/tb_prng_lfsr_stream.sv
// tb/tb_prng_lfsr_stream.sv - directed scoreboard bench for prng_lfsr_stream in three 8-bit configurations
module tb_prng_lfsr_stream;

  localparam logic [7:0] TP = 8'hB8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // A: 1 bit/word, DIV=1, no warm-up.  B: 8 bits, DIV=2.  C: 8 bits, DIV=3, WARMUP=4.
  logic       a_en, a_sv, a_sr, a_valid, a_ready, a_seeded;
  logic [7:0] a_seed, a_lfsr;
  logic [0:0] a_data;
  logic       b_en, b_sv, b_sr, b_valid, b_ready, b_seeded;
  logic [7:0] b_seed, b_lfsr, b_data;
  logic       c_en, c_sv, c_sr, c_valid, c_ready, c_seeded;
  logic [7:0] c_seed, c_lfsr, c_data;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  prng_lfsr_stream #(.WIDTH(8), .TAPS(TP), .OUT_BITS(1), .DIV(1), .WARMUP(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_seed(a_seed), .i_seed_valid(a_sv),
    .o_seed_ready(a_sr), .o_ks_data(a_data), .o_ks_valid(a_valid), .i_ks_ready(a_ready),
    .o_lfsr(a_lfsr), .o_seeded(a_seeded));

  prng_lfsr_stream #(.WIDTH(8), .TAPS(TP), .OUT_BITS(8), .DIV(2), .WARMUP(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_seed(b_seed), .i_seed_valid(b_sv),
    .o_seed_ready(b_sr), .o_ks_data(b_data), .o_ks_valid(b_valid), .i_ks_ready(b_ready),
    .o_lfsr(b_lfsr), .o_seeded(b_seeded));

  prng_lfsr_stream #(.WIDTH(8), .TAPS(TP), .OUT_BITS(8), .DIV(3), .WARMUP(4)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(c_en), .i_seed(c_seed), .i_seed_valid(c_sv),
    .o_seed_ready(c_sr), .o_ks_data(c_data), .o_ks_valid(c_valid), .i_ks_ready(c_ready),
    .o_lfsr(c_lfsr), .o_seeded(c_seeded));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference keystream: n single steps, out bit = s[7], shift left with parity feedback.
  function automatic logic [7:0] m_word(input logic [7:0] s, input int n, output logic [7:0] ns);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[6:0], s[7]};
      s = {s[6:0], ^(s & TP)};
    end
    ns = s;
    return w;
  endfunction

  task automatic fill_a(input logic [7:0] s, input int n);
    logic [7:0] st, ns;
    qa.delete();
    st = s;
    for (int i = 0; i < n; i++) begin qa.push_back(m_word(st, 1, ns)); st = ns; end
  endtask

  task automatic fill_b(input logic [7:0] s, input int n);
    logic [7:0] st, ns;
    qb.delete();
    st = s;
    for (int i = 0; i < n; i++) begin qb.push_back(m_word(st, 8, ns)); st = ns; end
  endtask

  task automatic fill_c(input logic [7:0] s, input int skip, input int n);
    logic [7:0] st, ns, w;
    qc.delete();
    st = s;
    for (int i = 0; i < skip + n; i++) begin
      w = m_word(st, 8, ns);
      st = ns;
      if (i >= skip) qc.push_back(w);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && a_valid && a_ready) begin
      if (qa.size() == 0) chk("a_unexpected_word", 32'(a_valid), 32'd0);
      else chk("a_word", 32'(a_data), 32'(qa.pop_front()));
    end
    if (rst_n === 1'b1 && b_valid && b_ready) begin
      if (qb.size() == 0) chk("b_unexpected_word", 32'(b_valid), 32'd0);
      else chk("b_word", 32'(b_data), 32'(qb.pop_front()));
    end
    if (rst_n === 1'b1 && c_valid && c_ready) begin
      if (qc.size() == 0) chk("c_unexpected_word", 32'(c_valid), 32'd0);
      else chk("c_word", 32'(c_data), 32'(qc.pop_front()));
    end
  end

  initial begin
    logic [7:0] hold_data, hold_lfsr, rec_lfsr;
    int         steps, lat;
    logic       zero_seen, data_stable, lfsr_stable, valid_seen;

    rst_n = 1'b0;
    a_en = 1'b1; a_sv = 1'b0; a_seed = '0; a_ready = 1'b1;
    b_en = 1'b1; b_sv = 1'b0; b_seed = '0; b_ready = 1'b1;
    c_en = 1'b1; c_sv = 1'b0; c_seed = '0; c_ready = 1'b1;
    repeat (2) step();

    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_data", 32'(a_data), 32'd0);
    chk("rst_a_seeded", 32'(a_seeded), 32'd0);
    chk("rst_a_lfsr", 32'(a_lfsr), 32'h01);
    chk("rst_a_seed_ready", 32'(a_sr), 32'd1);
    chk("rst_b_data", 32'(b_data), 32'd0);
    chk("rst_c_lfsr", 32'(c_lfsr), 32'h01);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_a_lfsr", 32'(a_lfsr), 32'h01);
    chk("idle_a_valid", 32'(a_valid), 32'd0);

    // Single-bit sequence from 0x80
    a_seed = 8'h80; a_sv = 1'b1; step(); a_sv = 1'b0;
    fill_a(8'h80, 300);
    chk("seed_a_lfsr", 32'(a_lfsr), 32'h80);
    chk("seed_a_seeded", 32'(a_seeded), 32'd1);
    chk("seed_a_valid", 32'(a_valid), 32'd0);
    step();
    chk("bit1_valid", 32'(a_valid), 32'd1);
    chk("bit1_data", 32'(a_data), 32'd1);
    chk("bit1_lfsr", 32'(a_lfsr), 32'h01);
    step();
    chk("bit2_data", 32'(a_data), 32'd0);
    chk("bit2_lfsr", 32'(a_lfsr), 32'h02);

    // Period from 0x01
    a_seed = 8'h01; a_sv = 1'b1; step(); a_sv = 1'b0;
    fill_a(8'h01, 300);
    chk("period_seed_lfsr", 32'(a_lfsr), 32'h01);
    zero_seen = 1'b0;
    steps = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (a_lfsr == 8'h00) zero_seen = 1'b1;
      if (a_lfsr == 8'h01) begin steps = k; break; end
    end
    chk("period_len", 32'(steps), 32'd255);
    chk("period_never_zero", 32'(zero_seen), 32'd0);

    // Zero seed behaves exactly like seed 0x01
    a_seed = 8'h00; a_sv = 1'b1; step(); a_sv = 1'b0;
    fill_a(8'h01, 300);
    chk("zero_seed_lfsr", 32'(a_lfsr), 32'h01);
    repeat (20) step();

    // Reseed while a word is being accepted
    chk("pre_reseed_valid", 32'(a_valid), 32'd1);
    a_seed = 8'hA5; a_sv = 1'b1; step(); a_sv = 1'b0;
    fill_a(8'hA5, 300);
    chk("reseed_valid_drop", 32'(a_valid), 32'd0);
    chk("reseed_lfsr", 32'(a_lfsr), 32'hA5);
    repeat (10) step();

    // Back-pressure on B
    b_seed = 8'h5A; b_sv = 1'b1; step(); b_sv = 1'b0;
    fill_b(8'h5A, 100);
    repeat (6) step();
    b_ready = 1'b0;
    for (int k = 0; k < 10 && !b_valid; k++) step();
    chk("bp_valid_held", 32'(b_valid), 32'd1);
    hold_data = b_data;
    hold_lfsr = b_lfsr;
    data_stable = 1'b1;
    lfsr_stable = 1'b1;
    repeat (10) begin
      step();
      if (b_data !== hold_data || b_valid !== 1'b1) data_stable = 1'b0;
      if (b_lfsr !== hold_lfsr) lfsr_stable = 1'b0;
    end
    chk("bp_data_stable", 32'(data_stable), 32'd1);
    chk("bp_lfsr_stable", 32'(lfsr_stable), 32'd1);
    b_ready = 1'b1;
    step();
    chk("bp_next_valid", 32'(b_valid), 32'd1);
    chk("bp_next_word", 32'(b_data), 32'(qb[0]));
    repeat (8) step();

    // Warm-up and first-word latency on C
    c_seed = 8'h3C; c_sv = 1'b1; step(); c_sv = 1'b0;
    fill_c(8'h3C, 4, 40);
    chk("warm_c_seeded", 32'(c_seeded), 32'd0);
    chk("warm_c_valid", 32'(c_valid), 32'd0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (c_valid) begin lat = k; break; end
    end
    chk("latency", 32'(lat), 32'd15);
    chk("run_c_seeded", 32'(c_seeded), 32'd1);
    chk("first_word", 32'(c_data), 32'(qc[0]));
    repeat (8) step();

    // i_en=0 freezes stepping but lets the last word drain
    c_en = 1'b0;
    step();
    rec_lfsr = c_lfsr;
    repeat (10) step();
    chk("en0_lfsr_hold", 32'(c_lfsr), 32'(rec_lfsr));
    chk("en0_valid_drained", 32'(c_valid), 32'd0);
    c_en = 1'b1;
    repeat (12) step();

    // Asynchronous reset mid-word
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid", 32'(a_valid), 32'd0);
    chk("arst_a_seeded", 32'(a_seeded), 32'd0);
    chk("arst_a_lfsr", 32'(a_lfsr), 32'h01);
    chk("arst_b_valid", 32'(b_valid), 32'd0);
    chk("arst_c_seeded", 32'(c_seeded), 32'd0);
    qa.delete(); qb.delete(); qc.delete();
    step();
    rst_n = 1'b1;
    valid_seen = 1'b0;
    repeat (12) begin
      step();
      if (a_valid || b_valid || c_valid) valid_seen = 1'b1;
    end
    chk("no_output_after_reset", 32'(valid_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
